// File: rtl/mem_access_unit_if.sv
// Pipeline-to-MEM-stage and data-bus signal bundle for mem_access_unit.
// The slave modport is the unit itself; the master modport is the pipeline/bus side.
interface mem_access_unit_if;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ready;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_fault;
  logic        o_bus_err;
  logic [31:0] o_fault_addr;

  modport slave (
    input  i_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata,
    input  i_dmem_ready, i_dmem_rvalid, i_dmem_rdata,
    output o_stall, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
    output o_rdata, o_rdata_valid, o_fault, o_bus_err, o_fault_addr
  );

  modport master (
    output i_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata,
    output i_dmem_ready, i_dmem_rvalid, i_dmem_rdata,
    input  o_stall, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
    input  o_rdata, o_rdata_valid, o_fault, o_bus_err, o_fault_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: store done in 2 cycles, load in 3 (plus bus wait states).
// Holds the bus request until i_dmem_ready and stalls the pipeline until done or timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstn,
  mem_access_unit_if.slave mau
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

  typedef struct packed {
    logic [29:0] word;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        fault_q, fault_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        start;
  logic        st_we;
  logic        illegal;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic        done;
  logic        expiring;
  logic        rdata_vld;
  logic        stall;
  logic [31:0] lane;
  logic [31:0] load_dat;

  always_comb begin
    start   = (state_q == IDLE) && mau.i_valid && (mau.i_mem_read || mau.i_mem_write);
    // read wins when both qualifiers are set
    st_we   = !mau.i_mem_read && mau.i_mem_write;
    illegal = (mau.i_funct3 == 3'b011) || (mau.i_funct3 == 3'b110) || (mau.i_funct3 == 3'b111)
           || (st_we && mau.i_funct3[2])
           || ((mau.i_funct3[1:0] == 2'b01) && mau.i_addr[0])
           || ((mau.i_funct3[1:0] == 2'b10) && (mau.i_addr[1:0] != 2'b00));

    fmt_be    = 4'b0000;
    fmt_wdata = mau.i_wdata;
    case (mau.i_funct3[1:0])
      2'b00: begin
        fmt_be    = 4'b0001 << mau.i_addr[1:0];
        fmt_wdata = {4{mau.i_wdata[7:0]}};
      end
      2'b01: begin
        fmt_be    = mau.i_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{mau.i_wdata[15:0]}};
      end
      2'b10:   fmt_be = 4'b1111;
      default: fmt_be = 4'b0000;
    endcase

    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    fault_d      = 1'b0;
    bus_err_d    = 1'b0;
    fault_addr_d = fault_addr_q;
    done         = 1'b0;
    expiring     = 1'b0;
    rdata_vld    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && illegal) begin
          fault_d      = 1'b1;
          fault_addr_d = mau.i_addr;
        end else if (start) begin
          req_d.word  = mau.i_addr[31:2];
          req_d.off   = mau.i_addr[1:0];
          req_d.size  = mau.i_funct3[1:0];
          req_d.uns   = mau.i_funct3[2];
          req_d.we    = st_we;
          req_d.wdata = fmt_wdata;
          req_d.be    = fmt_be;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mau.i_dmem_ready && req_q.we) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (mau.i_dmem_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mau.i_dmem_rvalid) begin
          done      = 1'b1;
          rdata_vld = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          expiring  = 1'b1;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    stall = (start && !illegal) || ((state_q != IDLE) && !done && !expiring);

    // halfword offsets are always 0 or 2, so the byte shift also selects the half lane
    lane = mau.i_dmem_rdata >> {req_q.off, 3'b000};
    case (req_q.size)
      2'b00:   load_dat = req_q.uns ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_dat = req_q.uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_dat = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      fault_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      fault_q      <= fault_d;
      bus_err_q    <= bus_err_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // every output is forced low while reset is held, including the combinational ones
  assign mau.o_stall       = rstn && stall;
  assign mau.o_dmem_req    = rstn && (state_q == REQ);
  assign mau.o_dmem_we     = rstn && (state_q == REQ) && req_q.we;
  assign mau.o_dmem_be     = (rstn && (state_q == REQ)) ? req_q.be : 4'b0000;
  assign mau.o_dmem_addr   = rstn ? {req_q.word, 2'b00} : 32'b0;
  assign mau.o_dmem_wdata  = rstn ? req_q.wdata : 32'b0;
  assign mau.o_rdata_valid = rstn && rdata_vld;
  assign mau.o_rdata       = (rstn && rdata_vld) ? load_dat : 32'b0;
  assign mau.o_fault       = rstn && fault_q;
  assign mau.o_bus_err     = rstn && bus_err_q;
  assign mau.o_fault_addr  = rstn ? fault_addr_q : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle expectations built at transaction level,
// checked by one compare process on the falling edge.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mau  (bus)
  );

  typedef struct {
    logic        stall;
    logic        req;
    logic        we;
    logic        chk_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rv;
    logic [31:0] rdata;
    logic        fault;
    logic        berr;
    logic [31:0] faddr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        pend_fault = 1'b0;
  logic        pend_berr  = 1'b0;
  logic [31:0] faddr_model = 32'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // spec-level formatting model
  function automatic void store_fmt(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, output logic [3:0] be,
                                    output logic [31:0] w);
    be = 4'b0000;
    case (f3[1:0])
      2'b00: begin be[a[1:0]] = 1'b1; w = {4{wd[7:0]}}; end
      2'b01: begin be = a[1] ? 4'b1100 : 4'b0011; w = {2{wd[15:0]}}; end
      default: begin be = 4'b1111; w = wd; end
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    int          x;
    v = rd >> (8 * a[1:0]);
    case (f3)
      3'b000: begin x = int'(v[7:0]);  if (x >= 128)   x -= 256;   return 32'(x); end
      3'b100:                                                      return 32'(v[7:0]);
      3'b001: begin x = int'(v[15:0]); if (x >= 32768) x -= 65536; return 32'(x); end
      3'b101:                                                      return 32'(v[15:0]);
      default:                                                     return rd;
    endcase
  endfunction

  function automatic exp_t e0();
    exp_t e;
    e.stall = 0; e.req = 0; e.we = 0; e.chk_wr = 0; e.addr = 0; e.wdata = 0; e.be = 0;
    e.rv = 0; e.rdata = 0; e.fault = 0; e.berr = 0; e.faddr = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32("stall",       32'(bus.o_stall),       32'(e.stall));
      check32("dmem_req",    32'(bus.o_dmem_req),    32'(e.req));
      check32("dmem_we",     32'(bus.o_dmem_we),     32'(e.we));
      check32("rdata_valid", 32'(bus.o_rdata_valid), 32'(e.rv));
      check32("rdata",       bus.o_rdata,            e.rdata);
      check32("fault",       32'(bus.o_fault),       32'(e.fault));
      check32("bus_err",     32'(bus.o_bus_err),     32'(e.berr));
      check32("fault_addr",  bus.o_fault_addr,       e.faddr);
      if (e.req) check32("dmem_addr", bus.o_dmem_addr, e.addr);
      if (e.req && e.chk_wr) begin
        check32("dmem_wdata", bus.o_dmem_wdata, e.wdata);
        check32("dmem_be",    32'(bus.o_dmem_be), 32'(e.be));
      end else if (!e.req) begin
        check32("dmem_be_idle", 32'(bus.o_dmem_be), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                        input logic rvl, input logic [31:0] rdat);
    bus.i_valid = v; bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_funct3 = f3;
    bus.i_addr = a; bus.i_wdata = wd; bus.i_dmem_ready = rdy;
    bus.i_dmem_rvalid = rvl; bus.i_dmem_rdata = rdat;
  endtask

  task automatic push(input exp_t e);
    e.fault = pend_fault; e.berr = pend_berr; e.faddr = faddr_model;
    pend_fault = 1'b0; pend_berr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(); set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0); push(e0());
    end
  endtask

  task automatic reset_cycle(input logic [31:0] rdat);
    step(); rstn = 1'b0;
    set_in(1, 1, 0, 3'b010, 32'h0000_1000, 32'h0, 1, 1, rdat);
    exp_q.push_back(e0());
    pend_fault = 1'b0; pend_berr = 1'b0; faddr_model = 32'b0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int nwait);
    exp_t e;
    logic [3:0] be;
    logic [31:0] w;
    store_fmt(f3, a, wd, be, w);
    step(); set_in(1, 0, 1, f3, a, wd, 0, 1, 32'h5A5A5A5A);
    e = e0(); e.stall = 1; push(e);
    e.req = 1; e.we = 1; e.chk_wr = 1; e.addr = {a[31:2], 2'b00}; e.wdata = w; e.be = be;
    for (int i = 0; i < nwait; i++) begin
      step(); set_in(1, 0, 1, f3, a, wd, 0, 1, 32'h5A5A5A5A); push(e);
    end
    step(); set_in(1, 0, 1, f3, a, wd, 1, 0, 32'h0);
    e.stall = 0; push(e);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat,
                         input int nrdy, input int nrv, input logic both);
    exp_t e;
    step(); set_in(1, 1, both, f3, a, 32'hFFFF_FFFF, 0, 1, 32'hA5A5A5A5);
    e = e0(); e.stall = 1; push(e);
    e.req = 1; e.addr = {a[31:2], 2'b00};
    for (int i = 0; i < nrdy; i++) begin
      step(); set_in(1, 1, both, f3, a, 32'hFFFF_FFFF, 0, 1, 32'hA5A5A5A5); push(e);
    end
    step(); set_in(1, 1, both, f3, a, 32'hFFFF_FFFF, 1, 1, 32'hA5A5A5A5); push(e);
    e.req = 0;
    for (int i = 0; i < nrv; i++) begin
      step(); set_in(1, 1, both, f3, a, 32'hFFFF_FFFF, 0, 0, 32'hA5A5A5A5); push(e);
    end
    step(); set_in(1, 1, both, f3, a, 32'hFFFF_FFFF, 0, 1, rdat);
    e.stall = 0; e.rv = 1; e.rdata = load_fmt(f3, a, rdat); push(e);
  endtask

  task automatic do_timeout(input logic [31:0] a);
    exp_t e;
    step(); set_in(1, 1, 0, 3'b010, a, 32'h0, 0, 0, 32'h0);
    e = e0(); e.stall = 1; push(e);
    step(); set_in(1, 1, 0, 3'b010, a, 32'h0, 1, 0, 32'h0);
    e.req = 1; e.addr = {a[31:2], 2'b00}; push(e);
    e.req = 0;
    for (int i = 0; i < TO; i++) begin
      step(); set_in(1, 1, 0, 3'b010, a, 32'h0, 0, 0, 32'h0);
      e.stall = (i < TO - 1); push(e);
    end
    pend_berr = 1'b1;
    step(); set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1, 32'h1234_5678); push(e0());
  endtask

  task automatic do_illegal(input logic [2:0] f3, input logic [31:0] a, input logic rd,
                            input logic wr);
    step(); set_in(1, rd, wr, f3, a, 32'hCAFE_F00D, 1, 0, 32'h0);
    push(e0());
    pend_fault = 1'b1; faddr_model = a;
  endtask

  task automatic do_reset_in_wait();
    exp_t e;
    step(); set_in(1, 1, 0, 3'b010, 32'h4000, 32'h0, 0, 0, 32'h0);
    e = e0(); e.stall = 1; push(e);
    step(); set_in(1, 1, 0, 3'b010, 32'h4000, 32'h0, 1, 0, 32'h0);
    e.req = 1; e.addr = 32'h4000; push(e);
    step(); set_in(1, 1, 0, 3'b010, 32'h4000, 32'h0, 0, 0, 32'h0);
    e.req = 0; push(e);
    reset_cycle(32'h0);
    step(); rstn = 1'b1;
    set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1, 32'h7777_7777); push(e0());
  endtask

  initial begin
    logic [3:0]  pbe;
    logic [31:0] pw;

    check32("pin_lw",  load_fmt(3'b010, 32'h1004, 32'hDEADBEEF), 32'hDEADBEEF);
    check32("pin_lb",  load_fmt(3'b000, 32'h1003, 32'h80112233), 32'hFFFFFF80);
    check32("pin_lbu", load_fmt(3'b100, 32'h1003, 32'h80112233), 32'h00000080);
    check32("pin_lhu", load_fmt(3'b101, 32'h1002, 32'h80112233), 32'h00008011);
    check32("pin_lh",  load_fmt(3'b001, 32'h1000, 32'h12348765), 32'hFFFF8765);
    store_fmt(3'b000, 32'h2001, 32'h000000AB, pbe, pw);
    check32("pin_sb_be", 32'(pbe), 32'(4'b0010));
    check32("pin_sb_wd", pw, 32'hABABABAB);
    store_fmt(3'b001, 32'h2002, 32'h1234CAFE, pbe, pw);
    check32("pin_sh_be", 32'(pbe), 32'(4'b1100));
    check32("pin_sh_wd", pw, 32'hCAFECAFE);

    set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) reset_cycle(32'hDEAD_0000);
    step(); rstn = 1'b1; set_in(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0); push(e0());
    idle(1);

    do_load(3'b010, 32'h1004, 32'hDEADBEEF, 0, 0, 0);
    do_load(3'b000, 32'h1003, 32'h80112233, 0, 0, 0);
    do_load(3'b100, 32'h1003, 32'h80112233, 0, 1, 0);
    do_load(3'b101, 32'h1002, 32'h80112233, 1, 0, 0);
    do_load(3'b001, 32'h1002, 32'h80112233, 0, 0, 0);
    do_load(3'b001, 32'h1000, 32'h12348765, 0, 0, 0);
    do_load(3'b000, 32'h1000, 32'h0000007F, 0, 0, 0);
    do_load(3'b100, 32'h1001, 32'h0000C300, 0, 0, 0);
    idle(1);

    do_store(3'b000, 32'h2001, 32'h000000AB, 3);
    do_store(3'b001, 32'h2002, 32'h1234CAFE, 0);
    do_store(3'b001, 32'h2000, 32'h0000BEEF, 1);
    do_store(3'b010, 32'h2004, 32'h01234567, 1);
    do_store(3'b000, 32'h2003, 32'h00000011, 0);
    do_load(3'b010, 32'h2008, 32'h11223344, 1, 2, 1);
    do_load(3'b010, 32'h200C, 32'h55667788, 2, 3, 0);
    idle(1);

    do_illegal(3'b010, 32'h3002, 1, 0);
    idle(2);
    do_illegal(3'b100, 32'h3000, 0, 1);
    do_illegal(3'b011, 32'h3004, 1, 0);
    idle(1);
    do_illegal(3'b001, 32'h3001, 1, 0);
    do_store(3'b000, 32'h3010, 32'h000000EE, 0);
    do_illegal(3'b001, 32'h3003, 0, 1);
    do_illegal(3'b111, 32'h3008, 1, 0);
    do_illegal(3'b010, 32'h3001, 0, 1);
    idle(2);

    do_timeout(32'h5000);
    idle(2);
    do_load(3'b010, 32'h5004, 32'hFEEDFACE, 0, 0, 0);

    do_reset_in_wait();
    idle(2);
    do_load(3'b101, 32'h6002, 32'hBEEF0000, 0, 0, 0);
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
